// File: rtl/mem_traffic_checker.sv
// Memory traffic checker: writes an LFSR pattern over a word range through an
// Avalon-MM master, reads it back with bounded outstanding reads and counts mismatches.
module mem_traffic_checker #(
   parameter int ADDR_W   = 29,
   parameter int MAX_PEND = 8
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       num_words,
   input  logic [31:0]       seed,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       error_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid
);
   // x^32+x^22+x^2+x+1 in right-shifting Galois form
   localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;
   localparam logic [4:0]        PEND_LIM  = 5'(MAX_PEND);
   localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;
   state_t state, state_nxt;

   logic [1:0]        rst_sync;
   logic              rst_n;
   logic [ADDR_W-1:0] base_q, addr, chk_addr, base_al;
   logic [31:0]       seed_q, iss_lfsr, chk_lfsr, seed_eff;
   logic [15:0]       nwords_q, cnt;
   logic [4:0]        outstanding;
   logic              wr_acc, rd_acc, rdv, last_issue, mismatch;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
   endfunction

   // Reset asserts immediately but releases two clocks after the pin deasserts
   always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) rst_sync <= 2'b00;
      else                rst_sync <= {rst_sync[0], 1'b1};
   assign rst_n = rst_sync[1];

   assign base_al    = {base_addr[ADDR_W-1:2], 2'b00};
   assign seed_eff   = (seed == 32'h0) ? 32'h1 : seed;
   assign wr_acc     = avm_write && !avm_waitrequest;
   assign rd_acc     = avm_read && !avm_waitrequest;
   assign rdv        = avm_readdatavalid && (state == READ || state == DRAIN);
   assign last_issue = (cnt == nwords_q - 16'd1);
   assign mismatch   = rdv && (avm_readdata != chk_lfsr);

   assign avm_write      = (state == WRITE);
   assign avm_read       = (state == READ) && (outstanding < PEND_LIM);
   assign avm_address    = addr;
   assign avm_writedata  = avm_write ? iss_lfsr : 32'h0;
   assign avm_byteenable = 4'hF;
   assign busy           = (state == WRITE) || (state == READ) || (state == DRAIN);
   assign done           = (state == FINISH);

   always_ff @(posedge clk_clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (num_words == 16'd0) ? FINISH : WRITE;
         WRITE:   if (wr_acc && last_issue) state_nxt = READ;
         READ:    if (rd_acc && last_issue) state_nxt = DRAIN;
         DRAIN:   if (outstanding == 5'd0 && !avm_readdatavalid) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q         <= '0;
         seed_q         <= 32'h1;
         nwords_q       <= '0;
         cnt            <= '0;
         addr           <= '0;
         iss_lfsr       <= 32'h1;
         chk_lfsr       <= 32'h1;
         chk_addr       <= '0;
         outstanding    <= '0;
         error_count    <= '0;
         first_err_addr <= '0;
         pass           <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               base_q         <= base_al;
               seed_q         <= seed_eff;
               nwords_q       <= num_words;
               cnt            <= '0;
               addr           <= base_al;
               iss_lfsr       <= seed_eff;
               chk_lfsr       <= seed_eff;
               chk_addr       <= base_al;
               outstanding    <= '0;
               error_count    <= '0;
               first_err_addr <= '0;
               pass           <= 1'b0;
            end
            WRITE: if (wr_acc) begin
               // Last write rewinds the issue side so reads replay the same range
               if (last_issue) begin
                  cnt      <= '0;
                  addr     <= base_q;
                  iss_lfsr <= seed_q;
               end else begin
                  cnt      <= cnt + 16'd1;
                  addr     <= addr + WORD_STEP;
                  iss_lfsr <= lfsr_step(iss_lfsr);
               end
            end
            READ: if (rd_acc) begin
               cnt  <= cnt + 16'd1;
               addr <= addr + WORD_STEP;
            end
            FINISH: pass <= (error_count == 16'd0);
            default: ;
         endcase

         if (rd_acc && !rdv)      outstanding <= outstanding + 5'd1;
         else if (!rd_acc && rdv) outstanding <= outstanding - 5'd1;

         if (rdv) begin
            chk_lfsr <= lfsr_step(chk_lfsr);
            chk_addr <= chk_addr + WORD_STEP;
            if (mismatch) begin
               if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
               if (error_count == 16'd0)    first_err_addr <= chk_addr;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_traffic_checker.sv
// Randomized bench for mem_traffic_checker: Avalon slave with random stalls and
// latency, pattern/address reference model, and per-scenario checks.
module tb_mem_traffic_checker;
   localparam int ADDR_W   = 29;
   localparam int MAX_PEND = 8;
   localparam logic [ADDR_W-1:0] ATOP = '1;

   logic              clk_clk = 1'b0;
   logic              reset_reset_n = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [15:0]       num_words = '0;
   logic [31:0]       seed = '0;
   logic              busy, done, pass;
   logic [15:0]       error_count;
   logic [ADDR_W-1:0] first_err_addr, avm_address;
   logic              avm_read, avm_write;
   logic [31:0]       avm_writedata;
   logic [3:0]        avm_byteenable;
   logic              avm_waitrequest = 1'b0;
   logic [31:0]       avm_readdata = '0;
   logic              avm_readdatavalid = 1'b0;

   int errors = 0;
   int checks = 0;

   mem_traffic_checker #(.ADDR_W(ADDR_W), .MAX_PEND(MAX_PEND)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .start(start),
      .base_addr(base_addr), .num_words(num_words), .seed(seed),
      .busy(busy), .done(done), .pass(pass), .error_count(error_count),
      .first_err_addr(first_err_addr), .avm_address(avm_address),
      .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
   );

   always #5 clk_clk = ~clk_clk;

   // ---------------- slave model ----------------
   int unsigned wait_pct = 0, lat_min = 2, lat_max = 2;
   bit          corrupt [int];
   logic [31:0] mem [logic [ADDR_W-1:0]];
   logic [ADDR_W-1:0] wr_addr_q[$], rd_addr_q[$];
   logic [31:0]       wr_data_q[$], pend_data[$];
   int                pend_due[$];
   int cyc = 0, last_due = 0, outst = 0, max_outst = 0, nrd = 0;
   int both_viol = 0, stab_viol = 0;
   logic prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
   logic [ADDR_W-1:0] prev_a = '0;
   logic [31:0] prev_d = '0, sl_d;
   int sl_due;

   always @(negedge clk_clk) begin
      cyc++;
      if (!reset_reset_n) begin
         pend_data.delete(); pend_due.delete();
         outst = 0; last_due = 0; prev_stall = 1'b0;
         avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
      end else begin
         if (avm_read && avm_write) both_viol++;
         if (prev_stall && (avm_read !== prev_rd || avm_write !== prev_wr ||
             avm_address !== prev_a || (prev_wr && avm_writedata !== prev_d))) stab_viol++;
         avm_readdatavalid = 1'b0;
         if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = pend_data.pop_front();
            void'(pend_due.pop_front());
            outst--;
         end
         avm_waitrequest = ($urandom_range(99, 0) < wait_pct);
         if ((avm_read || avm_write) && !avm_waitrequest) begin
            if (avm_write) begin
               mem[avm_address] = avm_writedata;
               wr_addr_q.push_back(avm_address);
               wr_data_q.push_back(avm_writedata);
            end else begin
               sl_d = mem.exists(avm_address) ? mem[avm_address] : 32'hDEAD_BEEF;
               if (corrupt.exists(nrd)) sl_d = sl_d ^ 32'h1;
               sl_due = cyc + int'($urandom_range(lat_max, lat_min));
               if (sl_due <= last_due) sl_due = last_due + 1;
               last_due = sl_due;
               pend_data.push_back(sl_d); pend_due.push_back(sl_due);
               outst++;
               if (outst > max_outst) max_outst = outst;
               rd_addr_q.push_back(avm_address);
               nrd++;
            end
         end
         prev_stall = (avm_read || avm_write) && avm_waitrequest;
         prev_rd = avm_read; prev_wr = avm_write;
         prev_a = avm_address; prev_d = avm_writedata;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [31:0] ref_word(input logic [31:0] s, input int k);
      logic [31:0] v, poly;
      poly = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | 32'h1;  // taps 32,22,2,1
      v = (s == 32'h0) ? 32'h1 : s;
      for (int i = 0; i < k; i++) v = (v >> 1) ^ (v[0] ? poly : 32'h0);
      return v;
   endfunction

   function automatic logic [ADDR_W-1:0] ref_addr(input logic [ADDR_W-1:0] b, input int k);
      logic [63:0] a;
      a = 64'(b) & ~64'h3;
      a = a + 64'(4 * k);
      return a[ADDR_W-1:0];
   endfunction

   function automatic int write_bad(input logic [ADDR_W-1:0] b, input int n, input logic [31:0] s);
      int bad;
      bad = (wr_addr_q.size() != n) ? 1 : 0;
      for (int k = 0; k < wr_addr_q.size() && k < n; k++)
         if (wr_addr_q[k] !== ref_addr(b, k) || wr_data_q[k] !== ref_word(s, k)) bad++;
      return bad;
   endfunction

   function automatic int read_bad(input logic [ADDR_W-1:0] b, input int n);
      int bad;
      bad = (rd_addr_q.size() != n) ? 1 : 0;
      for (int k = 0; k < rd_addr_q.size() && k < n; k++)
         if (rd_addr_q[k] !== ref_addr(b, k)) bad++;
      return bad;
   endfunction

   // Launch one run and wait (bounded) for its done pulse; no checking here.
   task automatic do_run(input logic [ADDR_W-1:0] b, input logic [15:0] n, input logic [31:0] s,
                         input bit extra_start, output bit to, output int done_cnt,
                         output int cyc_done, output logic busy1, output logic busy_d);
      @(negedge clk_clk);
      wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
      nrd = 0; max_outst = 0; both_viol = 0; stab_viol = 0;
      base_addr = b; num_words = n; seed = s; start = 1'b1;
      @(negedge clk_clk);
      start = 1'b0; busy1 = busy;
      to = 1'b1; done_cnt = 0; cyc_done = 0; busy_d = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (done === 1'b1) begin
            to = 1'b0; done_cnt = 1; cyc_done = i + 1; busy_d = busy;
            break;
         end
         if (extra_start && i == 5) begin
            start = 1'b1; base_addr = 'h800; num_words = 16'd3; seed = 32'h7;
         end else start = 1'b0;
         @(negedge clk_clk);
      end
      start = 1'b0;
      repeat (3) begin
         @(negedge clk_clk);
         if (done === 1'b1) done_cnt++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_reset_n = 1'b1;
      #2 reset_reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++;
         $display("FAIL reset_flags: busy=%b done=%b pass=%b want 0", busy, done, pass); end
      checks++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin errors++;
         $display("FAIL reset_req: rd=%b wr=%b want 0", avm_read, avm_write); end
      checks++; if (error_count !== 16'h0 || first_err_addr !== '0) begin errors++;
         $display("FAIL reset_err: cnt=%0h first=%0h want 0", error_count, first_err_addr); end
      checks++; if (avm_address !== '0 || avm_writedata !== 32'h0) begin errors++;
         $display("FAIL reset_bus: addr=%0h wdata=%0h want 0", avm_address, avm_writedata); end
      checks++; if (avm_byteenable !== 4'hF) begin errors++;
         $display("FAIL byteenable: got %0h want f", avm_byteenable); end
      repeat (3) @(negedge clk_clk);
      reset_reset_n = 1'b1;
      repeat (4) @(negedge clk_clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
         $display("FAIL post_reset_idle: busy=%b done=%b want 0", busy, done); end
   endtask

   task automatic test_basic();
      bit to; int dc, cd; logic b1, bd;
      wait_pct = 0; lat_min = 2; lat_max = 2;
      do_run('h100, 16'd16, 32'hACE1, 1'b0, to, dc, cd, b1, bd);
      checks++; if (to) begin errors++; $display("FAIL basic_timeout: no done"); end
      checks++; if (b1 !== 1'b1 || bd !== 1'b0) begin errors++;
         $display("FAIL basic_busy: after start=%b at done=%b want 1/0", b1, bd); end
      checks++; if (write_bad('h100, 16, 32'hACE1) != 0) begin errors++;
         $display("FAIL basic_writes: %0d writes seen, %0d bad, want 16 clean",
                  wr_addr_q.size(), write_bad('h100, 16, 32'hACE1)); end
      checks++; if (read_bad('h100, 16) != 0) begin errors++;
         $display("FAIL basic_reads: %0d reads seen, want 16 at ascending addrs", rd_addr_q.size()); end
      checks++; if (dc != 1) begin errors++; $display("FAIL basic_done: %0d pulses want 1", dc); end
      checks++; if (error_count !== 16'h0 || pass !== 1'b1) begin errors++;
         $display("FAIL basic_result: errs=%0d pass=%b want 0/1", error_count, pass); end
   endtask

   task automatic test_corrupt();
      bit to; int dc, cd; logic b1, bd;
      wait_pct = 0; lat_min = 2; lat_max = 2;
      corrupt[5] = 1'b1; corrupt[9] = 1'b1;
      do_run('h100, 16'd16, 32'hACE1, 1'b0, to, dc, cd, b1, bd);
      corrupt.delete();
      checks++; if (to) begin errors++; $display("FAIL corrupt_timeout: no done"); end
      checks++; if (error_count !== 16'd2) begin errors++;
         $display("FAIL corrupt_count: got %0d want 2", error_count); end
      checks++; if (first_err_addr !== ref_addr('h100, 5)) begin errors++;
         $display("FAIL corrupt_first: got %0h want %0h", first_err_addr, ref_addr('h100, 5)); end
      checks++; if (pass !== 1'b0) begin errors++; $display("FAIL corrupt_pass: got %b want 0", pass); end
   endtask

   task automatic test_zero();
      bit to; int dc, cd; logic b1, bd;
      do_run('h40, 16'd0, 32'h5, 1'b0, to, dc, cd, b1, bd);
      checks++; if (to || cd > 2) begin errors++;
         $display("FAIL zero_latency: timeout=%b cycles=%0d want <=2", to, cd); end
      checks++; if (wr_addr_q.size() != 0 || nrd != 0) begin errors++;
         $display("FAIL zero_traffic: writes=%0d reads=%0d want 0", wr_addr_q.size(), nrd); end
      checks++; if (pass !== 1'b1 || dc != 1) begin errors++;
         $display("FAIL zero_result: pass=%b done=%0d want 1/1", pass, dc); end
   endtask

   task automatic test_start_busy();
      bit to; int dc, cd; logic b1, bd;
      wait_pct = 0; lat_min = 3; lat_max = 3;
      do_run('h200, 16'd10, 32'h1234, 1'b1, to, dc, cd, b1, bd);
      checks++; if (to || dc != 1) begin errors++;
         $display("FAIL busy_start_done: timeout=%b pulses=%0d want 0/1", to, dc); end
      checks++; if (write_bad('h200, 10, 32'h1234) != 0 || read_bad('h200, 10) != 0) begin errors++;
         $display("FAIL busy_start_traffic: writes=%0d reads=%0d want 10/10 of first run",
                  wr_addr_q.size(), rd_addr_q.size()); end
      checks++; if (pass !== 1'b1) begin errors++; $display("FAIL busy_start_pass: got %b want 1", pass); end
   endtask

   task automatic test_random();
      bit to; int dc, cd; logic b1, bd;
      logic [ADDR_W-1:0] b; logic [15:0] n; logic [31:0] s;
      wait_pct = 50; lat_min = 1; lat_max = 20;
      for (int it = 0; it < 3; it++) begin
         b = ADDR_W'($urandom); n = 16'($urandom_range(48, 20)); s = $urandom;
         do_run(b, n, s, 1'b0, to, dc, cd, b1, bd);
         checks++; if (to) begin errors++; $display("FAIL rand_timeout: iter %0d", it); end
         checks++; if (write_bad(b, int'(n), s) != 0 || read_bad(b, int'(n)) != 0) begin errors++;
            $display("FAIL rand_traffic: iter %0d writes=%0d reads=%0d want %0d",
                     it, wr_addr_q.size(), rd_addr_q.size(), n); end
         checks++; if (max_outst > MAX_PEND) begin errors++;
            $display("FAIL rand_outstanding: peak %0d limit %0d", max_outst, MAX_PEND); end
         checks++; if (stab_viol != 0 || both_viol != 0) begin errors++;
            $display("FAIL rand_protocol: unstable=%0d rd_and_wr=%0d want 0", stab_viol, both_viol); end
         checks++; if (pass !== 1'b1 || error_count !== 16'h0) begin errors++;
            $display("FAIL rand_result: pass=%b errs=%0d want 1/0", pass, error_count); end
      end
   endtask

   task automatic test_reset_mid();
      bit to, hit; int dc, cd, dseen; logic b1, bd;
      wait_pct = 0; lat_min = 20; lat_max = 20;
      @(negedge clk_clk);
      wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete(); nrd = 0;
      base_addr = 'h300; num_words = 16'd16; seed = 32'hBEEF; start = 1'b1;
      @(negedge clk_clk);
      start = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk_clk);
         if (nrd >= 3 && nrd < 16 && outst >= 3) begin hit = 1'b1; break; end
      end
      checks++; if (!hit) begin errors++; $display("FAIL midreset_reach: READ with 3 pending not seen"); end
      #2 reset_reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || avm_read !== 1'b0 || avm_write !== 1'b0) begin
         errors++; $display("FAIL midreset_ctrl: busy=%b done=%b rd=%b wr=%b want 0",
                            busy, done, avm_read, avm_write); end
      checks++; if (avm_address !== '0 || error_count !== 16'h0 || pass !== 1'b0) begin errors++;
         $display("FAIL midreset_regs: addr=%0h errs=%0d pass=%b want 0", avm_address, error_count, pass); end
      dseen = 0;
      repeat (3) begin @(negedge clk_clk); if (done === 1'b1) dseen++; end
      reset_reset_n = 1'b1;
      repeat (4) begin @(negedge clk_clk); if (done === 1'b1) dseen++; end
      checks++; if (dseen != 0) begin errors++; $display("FAIL midreset_done: %0d pulses want 0", dseen); end
      lat_min = 1; lat_max = 6;
      do_run('h300, 16'd16, 32'hBEEF, 1'b0, to, dc, cd, b1, bd);
      checks++; if (to || pass !== 1'b1 || write_bad('h300, 16, 32'hBEEF) != 0) begin errors++;
         $display("FAIL midreset_rerun: timeout=%b pass=%b writes=%0d", to, pass, wr_addr_q.size()); end
   endtask

   task automatic test_wrap();
      bit to; int dc, cd; logic b1, bd;
      logic [ADDR_W-1:0] b;
      b = ATOP - ADDR_W'(7);
      wait_pct = 0; lat_min = 2; lat_max = 2;
      do_run(b, 16'd4, 32'h0, 1'b0, to, dc, cd, b1, bd);
      checks++; if (to || wr_addr_q.size() != 4) begin errors++;
         $display("FAIL wrap_count: timeout=%b writes=%0d want 4", to, wr_addr_q.size()); end
      else begin
         checks++; if (wr_data_q[0] !== 32'h1) begin errors++;
            $display("FAIL seed_zero: first word %0h want 1", wr_data_q[0]); end
         checks++; if (wr_addr_q[2] !== '0 || wr_addr_q[3] !== ADDR_W'(4)) begin errors++;
            $display("FAIL wrap_addr: got %0h,%0h want 0,4", wr_addr_q[2], wr_addr_q[3]); end
      end
      checks++; if (write_bad(b, 4, 32'h0) != 0 || read_bad(b, 4) != 0 || pass !== 1'b1) begin errors++;
         $display("FAIL wrap_run: pass=%b reads=%0d want clean pass", pass, rd_addr_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_corrupt();
      test_zero();
      test_start_busy();
      test_random();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
